// File: rtl/spi_regbridge.sv
// spi_regbridge
// SPI slave register bridge between the host SPI master and the robot's
// telemetry/control logic. Reads stream a coherent snapshot of N_CH telemetry
// channels (MSB byte first, auto-incrementing channel index with wrap).
// Writes to index 0 update the control register. A status byte is returned
// while the command byte is being received. Supports SPI modes 0..3.
//
// Ports:
//   SPI_REGBRIDGE_CLOCK_50           system clock, rising edge
//   SPI_REGBRIDGE_RESET_InHigh       synchronous active-high reset
//   SPI_REGBRIDGE_SS_InLow           slave select (active low, asynchronous)
//   SPI_REGBRIDGE_SCK_In             SPI clock (asynchronous, <= CLOCK_50/8)
//   SPI_REGBRIDGE_MOSI_In            master-out data, MSB first
//   SPI_REGBRIDGE_CHANNELS_InBus     telemetry, channel k at [k*CH_WIDTH +: CH_WIDTH]
//   SPI_REGBRIDGE_MISO_Out           master-in data, 0 while idle
//   SPI_REGBRIDGE_WAYSELECT_OutBus   way-select register
//   SPI_REGBRIDGE_STOPSIGNAL_OutLow  stop level, 0 = stop
//   SPI_REGBRIDGE_BEGINSIGNAL_OutLow begin strobe, low for one cycle
//   SPI_REGBRIDGE_NEWSIGNAL_Out      one-cycle pulse per accepted control write
//   SPI_REGBRIDGE_ERROR_Out          sticky protocol-error flag
module spi_regbridge #(
    parameter int N_CH     = 11,
    parameter int CH_WIDTH = 17,
    parameter int SPI_MODE = 0
) (
    input  logic                     SPI_REGBRIDGE_CLOCK_50,
    input  logic                     SPI_REGBRIDGE_RESET_InHigh,
    input  logic                     SPI_REGBRIDGE_SS_InLow,
    input  logic                     SPI_REGBRIDGE_SCK_In,
    input  logic                     SPI_REGBRIDGE_MOSI_In,
    input  logic [N_CH*CH_WIDTH-1:0] SPI_REGBRIDGE_CHANNELS_InBus,
    output logic                     SPI_REGBRIDGE_MISO_Out,
    output logic [2:0]               SPI_REGBRIDGE_WAYSELECT_OutBus,
    output logic                     SPI_REGBRIDGE_STOPSIGNAL_OutLow,
    output logic                     SPI_REGBRIDGE_BEGINSIGNAL_OutLow,
    output logic                     SPI_REGBRIDGE_NEWSIGNAL_Out,
    output logic                     SPI_REGBRIDGE_ERROR_Out
);

    localparam int BPC   = (CH_WIDTH + 7) / 8;
    localparam int PAD_W = BPC * 8;
    localparam bit CPOL  = ((SPI_MODE / 2) % 2) == 1;
    localparam bit CPHA  = (SPI_MODE % 2) == 1;
    // Data is sampled on the rising SCK edge exactly when CPOL equals CPHA.
    localparam bit SAMPLE_ON_RISE = (CPOL == CPHA);
    localparam logic [6:0] LAST_CH   = 7'(N_CH - 1);
    localparam logic [1:0] LAST_BYTE = 2'(BPC - 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        RD_DATA,
        WR_CTRL,
        WR_IGNORE,
        WAIT_SS
    } state_t;

    logic       clk;
    logic       reset;
    assign clk   = SPI_REGBRIDGE_CLOCK_50;
    assign reset = SPI_REGBRIDGE_RESET_InHigh;

    logic [1:0] ss_sync, sck_sync, mosi_sync;
    logic       ss_prev, sck_prev;
    logic       ss_fall_p, ss_rise_p, sample_p, drive_p, mosi_bit;
    logic       ss_level;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [6:0] rx_sr;
    logic [7:0] tx_sr;
    logic       miso;
    logic [N_CH*CH_WIDTH-1:0] snapshot;
    logic [6:0] ch_idx;
    logic [1:0] byte_idx;
    logic       rd_valid;
    logic [2:0] waysel;
    logic       stop_n;
    logic       begin_n;
    logic       newsig;
    logic       error;

    logic [7:0] rx_byte;
    logic [6:0] rx_idx;
    logic       rx_idx_valid;
    logic [7:0] status;
    logic       in_txn;
    logic       byte_done;
    logic       err_set, err_clr;
    logic [6:0] nxt_ch_idx;
    logic [1:0] nxt_byte_idx;
    logic [7:0] nxt_data;
    logic [7:0] first_data;

    // Byte b (0 = most significant) of channel ch, after zero-extension to
    // a whole number of bytes.
    function automatic logic [7:0] pick_byte(input logic [N_CH*CH_WIDTH-1:0] bus,
                                             input int ch, input int b);
        logic [PAD_W-1:0] pad;
        pad = '0;
        pad[CH_WIDTH-1:0] = bus[ch*CH_WIDTH +: CH_WIDTH];
        return pad[(BPC-1-b)*8 +: 8];
    endfunction

    // Plain two-flop synchronisers; they only track the pins, so no reset.
    always_ff @(posedge clk) begin
        ss_sync   <= {ss_sync[0], SPI_REGBRIDGE_SS_InLow};
        sck_sync  <= {sck_sync[0], SPI_REGBRIDGE_SCK_In};
        mosi_sync <= {mosi_sync[0], SPI_REGBRIDGE_MOSI_In};
        ss_prev   <= ss_sync[1];
        sck_prev  <= sck_sync[1];
    end

    assign ss_level = ss_sync[1];

    // Registered edge pulses; mosi_bit is captured alongside so it lines up
    // with the sampling pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            ss_fall_p <= 1'b0;
            ss_rise_p <= 1'b0;
            sample_p  <= 1'b0;
            drive_p   <= 1'b0;
            mosi_bit  <= 1'b0;
        end else begin
            ss_fall_p <= ss_prev & ~ss_sync[1];
            ss_rise_p <= ~ss_prev & ss_sync[1];
            if (SAMPLE_ON_RISE) begin
                sample_p <= ~sck_prev & sck_sync[1];
                drive_p  <= sck_prev & ~sck_sync[1];
            end else begin
                sample_p <= sck_prev & ~sck_sync[1];
                drive_p  <= ~sck_prev & sck_sync[1];
            end
            mosi_bit <= mosi_sync[1];
        end
    end

    always_comb begin
        rx_byte      = {rx_sr, mosi_bit};
        rx_idx       = rx_byte[6:0];
        rx_idx_valid = int'(rx_idx) < N_CH;
        status       = {2'b10, error, ~stop_n, 1'b0, waysel};
        in_txn       = (state != IDLE) && (state != WAIT_SS);
        byte_done    = in_txn && !ss_rise_p && sample_p && (bit_cnt == 3'd7);
        err_set      = byte_done && (((state == CMD) && rx_byte[7] && !rx_idx_valid)
                                     || (state == WR_IGNORE));
        err_clr      = byte_done && (state == WR_CTRL) && rx_byte[7];

        nxt_byte_idx = byte_idx + 2'd1;
        nxt_ch_idx   = ch_idx;
        if (byte_idx == LAST_BYTE) begin
            nxt_byte_idx = 2'd0;
            nxt_ch_idx   = (ch_idx == LAST_CH) ? 7'd0 : ch_idx + 7'd1;
        end
        nxt_data   = rd_valid ? pick_byte(snapshot, int'(nxt_ch_idx), int'(nxt_byte_idx)) : 8'h00;
        // The first data byte is taken from the live bus in the same cycle the
        // snapshot is captured, so it matches the snapshot exactly.
        first_data = rx_idx_valid
                   ? pick_byte(SPI_REGBRIDGE_CHANNELS_InBus, int'(rx_idx), 0) : 8'h00;
    end

    // Transaction FSM with registered MISO and control outputs. The next
    // byte is loaded into tx_sr on the sampling edge that completes the
    // previous byte, so the following driving edge presents its MSB.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= WAIT_SS;
            bit_cnt  <= 3'd0;
            rx_sr    <= 7'd0;
            tx_sr    <= 8'd0;
            miso     <= 1'b0;
            snapshot <= '0;
            ch_idx   <= 7'd0;
            byte_idx <= 2'd0;
            rd_valid <= 1'b0;
            waysel   <= 3'd0;
            stop_n   <= 1'b0;
            begin_n  <= 1'b1;
            newsig   <= 1'b0;
            error    <= 1'b0;
        end else begin
            begin_n <= 1'b1;
            newsig  <= 1'b0;
            // Set takes priority over a simultaneous clear.
            error   <= err_set | (error & ~err_clr);

            case (state)
                WAIT_SS: begin
                    miso    <= 1'b0;
                    bit_cnt <= 3'd0;
                    if (ss_level) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    miso    <= 1'b0;
                    bit_cnt <= 3'd0;
                    if (ss_fall_p) begin
                        state <= CMD;
                        // With CPHA=0 the first bit must be on the line
                        // before the first (sampling) edge.
                        if (!CPHA) begin
                            miso  <= status[7];
                            tx_sr <= {status[6:0], 1'b0};
                        end else begin
                            tx_sr <= status;
                        end
                    end
                end
                default: begin
                    if (ss_rise_p) begin
                        state   <= IDLE;
                        bit_cnt <= 3'd0;
                        miso    <= 1'b0;
                    end else begin
                        if (drive_p) begin
                            miso  <= tx_sr[7];
                            tx_sr <= {tx_sr[6:0], 1'b0};
                        end
                        if (sample_p) begin
                            rx_sr   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                        if (byte_done) begin
                            case (state)
                                CMD: begin
                                    if (rx_byte[7]) begin
                                        state    <= RD_DATA;
                                        snapshot <= SPI_REGBRIDGE_CHANNELS_InBus;
                                        ch_idx   <= rx_idx;
                                        byte_idx <= 2'd0;
                                        rd_valid <= rx_idx_valid;
                                        tx_sr    <= first_data;
                                    end else if (rx_idx == 7'd0) begin
                                        state <= WR_CTRL;
                                    end else begin
                                        state <= WR_IGNORE;
                                    end
                                end
                                RD_DATA: begin
                                    ch_idx   <= nxt_ch_idx;
                                    byte_idx <= nxt_byte_idx;
                                    tx_sr    <= nxt_data;
                                end
                                WR_CTRL: begin
                                    waysel  <= rx_byte[2:0];
                                    stop_n  <= ~rx_byte[3];
                                    begin_n <= ~rx_byte[4];
                                    newsig  <= 1'b1;
                                    state   <= WR_IGNORE;
                                end
                                default: begin
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign SPI_REGBRIDGE_MISO_Out           = miso;
    assign SPI_REGBRIDGE_WAYSELECT_OutBus   = waysel;
    assign SPI_REGBRIDGE_STOPSIGNAL_OutLow  = stop_n;
    assign SPI_REGBRIDGE_BEGINSIGNAL_OutLow = begin_n;
    assign SPI_REGBRIDGE_NEWSIGNAL_Out      = newsig;
    assign SPI_REGBRIDGE_ERROR_Out          = error;

endmodule

// File: tb/tb_spi_regbridge.sv
// tb_spi_regbridge
// Testbench for spi_regbridge. One instance per SPI mode (0..3), each with
// its own slave select and SCK, sharing MOSI and the telemetry bus. A small
// transaction-level model per instance predicts status bytes, read data and
// control register contents.
module tb_spi_regbridge;

    localparam int N_CH     = 11;
    localparam int CH_WIDTH = 17;
    localparam int BPC      = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] ss   = 4'b1111;
    logic [3:0] sck  = 4'b1100;
    logic       mosi = 1'b0;
    logic [3:0] miso_w, stop_w, begin_w, new_w, err_w;
    logic [11:0] way_w;
    logic [N_CH*CH_WIDTH-1:0] chan_bus;
    logic [CH_WIDTH-1:0] chv  [N_CH];
    logic [CH_WIDTH-1:0] snap [N_CH];
    logic [7:0] wbuf [8];

    // Per-instance model state.
    logic [2:0] m_way  [4];
    logic       m_stop [4];
    logic       m_err  [4];
    int new_cnt [4];
    int beg_cnt [4];

    int total = 0;
    int bad   = 0;

    always #10 clk = ~clk;

    always_comb begin
        chan_bus = '0;
        for (int k = 0; k < N_CH; k++) chan_bus[k*CH_WIDTH +: CH_WIDTH] = chv[k];
    end

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_regbridge #(.N_CH(N_CH), .CH_WIDTH(CH_WIDTH), .SPI_MODE(g)) u_dut (
            .SPI_REGBRIDGE_CLOCK_50          (clk),
            .SPI_REGBRIDGE_RESET_InHigh      (rst),
            .SPI_REGBRIDGE_SS_InLow          (ss[g]),
            .SPI_REGBRIDGE_SCK_In            (sck[g]),
            .SPI_REGBRIDGE_MOSI_In           (mosi),
            .SPI_REGBRIDGE_CHANNELS_InBus    (chan_bus),
            .SPI_REGBRIDGE_MISO_Out          (miso_w[g]),
            .SPI_REGBRIDGE_WAYSELECT_OutBus  (way_w[g*3 +: 3]),
            .SPI_REGBRIDGE_STOPSIGNAL_OutLow (stop_w[g]),
            .SPI_REGBRIDGE_BEGINSIGNAL_OutLow(begin_w[g]),
            .SPI_REGBRIDGE_NEWSIGNAL_Out     (new_w[g]),
            .SPI_REGBRIDGE_ERROR_Out         (err_w[g])
        );
    end

    // Count cycles of NEWSIGNAL high and BEGIN low; a correct strobe adds 1.
    always @(posedge clk) begin
        for (int g = 0; g < 4; g++) begin
            if (new_w[g])    new_cnt[g]++;
            if (!begin_w[g]) beg_cnt[g]++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] status_of(input int m);
        return {2'b10, m_err[m], m_stop[m], 1'b0, m_way[m]};
    endfunction

    // k-th data byte of a burst starting at channel idx, from the snapshot.
    function automatic logic [7:0] ref_byte(input int idx, input int k);
        int ch;
        int b;
        logic [31:0] v;
        ch = (idx + k / BPC) % N_CH;
        b  = k % BPC;
        v  = 32'(snap[ch]);
        return 8'(v >> (8 * (BPC - 1 - b)));
    endfunction

    task automatic half_bit();
        repeat (6) @(negedge clk);
    endtask

    task automatic ss_low(input int m);
        ss[m] = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic ss_high(input int m);
        repeat (6) @(negedge clk);
        ss[m] = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    // Master side of nbits bit-times, MSB first, in the mode of instance m.
    task automatic spi_bits(input int m, input logic [7:0] tx, input int nbits,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (m % 2 == 0) begin
                mosi = tx[i];
                half_bit();
                rx[i] = miso_w[m];
                sck[m] = ~sck[m];
                half_bit();
                sck[m] = ~sck[m];
            end else begin
                sck[m] = ~sck[m];
                mosi = tx[i];
                half_bit();
                rx[i] = miso_w[m];
                sck[m] = ~sck[m];
                half_bit();
            end
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < 4; g++) begin
            m_way[g]  = 3'd0;
            m_stop[g] = 1'b1;
            m_err[g]  = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_reset();
    endtask

    task automatic check_regs(input int m);
        checkOutput("wayselect", 32'(way_w[m*3 +: 3]), 32'(m_way[m]));
        checkOutput("stop_n", 32'(stop_w[m]), 32'(!m_stop[m]));
        checkOutput("error", 32'(err_w[m]), 32'(m_err[m]));
        checkOutput("begin_idle", 32'(begin_w[m]), 32'd1);
        checkOutput("new_idle", 32'(new_w[m]), 32'd0);
    endtask

    // One complete transaction: command plus ndata bytes from wbuf. For reads,
    // channels 10 and 0 are re-randomised after data byte chg_at.
    task automatic applyStimulus(input int m, input logic [7:0] cmd, input int ndata,
                                 input int chg_at);
        logic [7:0] rx;
        logic [7:0] exp;
        int idx, n0, b0, exp_new, exp_beg;
        for (int k = 0; k < N_CH; k++) snap[k] = chv[k];
        n0  = new_cnt[m];
        b0  = beg_cnt[m];
        idx = int'(cmd[6:0]);
        exp = status_of(m);
        ss_low(m);
        spi_bits(m, cmd, 8, rx);
        checkOutput("status", 32'(rx), 32'(exp));
        if (cmd[7]) begin
            if (idx >= N_CH) m_err[m] = 1'b1;
            for (int k = 0; k < ndata; k++) begin
                spi_bits(m, wbuf[k], 8, rx);
                exp = (idx < N_CH) ? ref_byte(idx, k) : 8'h00;
                checkOutput("rd_data", 32'(rx), 32'(exp));
                if (k == chg_at) begin
                    chv[10] = CH_WIDTH'($urandom);
                    chv[0]  = CH_WIDTH'($urandom);
                end
            end
        end else begin
            for (int k = 0; k < ndata; k++) begin
                spi_bits(m, wbuf[k], 8, rx);
                if (k == 0 && idx == 0) begin
                    m_way[m]  = wbuf[0][2:0];
                    m_stop[m] = wbuf[0][3];
                    if (wbuf[0][7]) m_err[m] = 1'b0;
                end else begin
                    m_err[m] = 1'b1;
                end
            end
        end
        ss_high(m);
        exp_new = (!cmd[7] && idx == 0 && ndata > 0) ? 1 : 0;
        exp_beg = (exp_new == 1 && wbuf[0][4]) ? 1 : 0;
        checkOutput("new_pulses", 32'(new_cnt[m] - n0), 32'(exp_new));
        checkOutput("begin_pulses", 32'(beg_cnt[m] - b0), 32'(exp_beg));
        check_regs(m);
    endtask

    initial begin
        logic [7:0] rx;
        int m, nd, n0;
        logic [7:0] cmd;

        for (int k = 0; k < N_CH; k++) chv[k] = CH_WIDTH'($urandom);
        for (int k = 0; k < 8; k++) wbuf[k] = 8'($urandom);

        // Reset values on every instance, then status after reset.
        do_reset();
        for (int g = 0; g < 4; g++) begin
            check_regs(g);
            checkOutput("miso_reset", 32'(miso_w[g]), 32'd0);
        end
        applyStimulus(0, 8'h80, 0, -1);

        // Burst read of channels 2 and 3 in every mode.
        chv[2] = 17'h1ABCD;
        chv[3] = 17'h00042;
        for (int g = 0; g < 4; g++) applyStimulus(g, 8'h82, 6, -1);

        // Coherency across wrap: ch10 then ch0, changed mid-burst.
        applyStimulus(0, 8'h8A, 6, 0);
        applyStimulus(3, 8'h8A, 6, 0);

        // Out-of-range read, error visible in status, then cleared by write.
        applyStimulus(0, 8'h8B, 2, -1);
        applyStimulus(0, 8'h80, 0, -1);
        wbuf[0] = 8'h88;
        applyStimulus(0, 8'h00, 1, -1);

        // Control write and the resulting status byte.
        wbuf[0] = 8'h15;
        applyStimulus(0, 8'h00, 1, -1);
        applyStimulus(0, 8'h80, 0, -1);

        // Abort after 5 data bits: nothing may change.
        n0 = new_cnt[0];
        ss_low(0);
        spi_bits(0, 8'h00, 8, rx);
        spi_bits(0, 8'hFF, 5, rx);
        ss_high(0);
        checkOutput("abort_new", 32'(new_cnt[0] - n0), 32'd0);
        check_regs(0);
        applyStimulus(0, 8'h80, 0, -1);
        wbuf[0] = 8'h0B;
        applyStimulus(0, 8'h00, 1, -1);

        // Reset in the middle of a transaction, then a normal one.
        ss_low(2);
        spi_bits(2, 8'h00, 3, rx);
        do_reset();
        check_regs(2);
        ss_high(2);
        applyStimulus(2, 8'h80, 1, -1);

        // Randomised traffic across all modes.
        for (int t = 0; t < 30; t++) begin
            m = $urandom_range(0, 3);
            if ($urandom % 3 == 0)
                for (int k = 0; k < N_CH; k++) chv[k] = CH_WIDTH'($urandom);
            for (int k = 0; k < 8; k++) wbuf[k] = 8'($urandom);
            if ($urandom % 2 == 0) begin
                cmd = {1'b1, 7'($urandom_range(0, 14))};
                nd  = $urandom_range(0, 7);
                applyStimulus(m, cmd, nd, (nd > 0) ? int'($urandom_range(0, nd - 1)) : -1);
            end else begin
                cmd = ($urandom % 4 == 0) ? {1'b0, 7'($urandom_range(1, 127))} : 8'h00;
                nd  = $urandom_range(0, 2);
                applyStimulus(m, cmd, nd, -1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_regbridge.md
# spi_regbridge

Parametrised SPI slave register bridge. It is the successor to the fixed 8-bit SPI slave and message-interpreter pair, and sits between the external SPI master (the host processor) and the robot's telemetry and control logic. It serves N_CH telemetry channels of arbitrary width as coherent, auto-incrementing burst reads. It also accepts control writes that drive way-select, stop and begin signals. Unlike its predecessor, it supports all four SPI modes, snapshot-coherent multi-byte reads, and a status byte returned during the command byte. A sticky error flag reports protocol faults.

## Interface
- N_CH, 11, number of telemetry channels (1..128).
- CH_WIDTH, 17, bits per channel (1..32). BYTES_PER_CH = ceil(CH_WIDTH/8). Each channel is zero-extended to BYTES_PER_CH*8 bits.
- SPI_MODE, 0, SPI mode 0..3, encoded {CPOL,CPHA}.

- SPI_REGBRIDGE_CLOCK_50  in  1  system clock; all logic is on its rising edge.
- SPI_REGBRIDGE_RESET_InHigh  in  1  synchronous, active-high reset.
- SPI_REGBRIDGE_SS_InLow  in  1  slave select, active low, asynchronous to the clock.
- SPI_REGBRIDGE_SCK_In  in  1  SPI clock, asynchronous; maximum frequency is CLOCK_50/8.
- SPI_REGBRIDGE_MOSI_In  in  1  master-out data, MSB first.
- SPI_REGBRIDGE_CHANNELS_InBus  in  N_CH*CH_WIDTH  telemetry; channel k occupies bits [k*CH_WIDTH +: CH_WIDTH].
- SPI_REGBRIDGE_MISO_Out  in/out: out  1  master-in data, MSB first; driven 0 while SS is high.
- SPI_REGBRIDGE_WAYSELECT_OutBus  out  3  way-select register.
- SPI_REGBRIDGE_STOPSIGNAL_OutLow  out  1  stop level; 0 means stop.
- SPI_REGBRIDGE_BEGINSIGNAL_OutLow  out  1  begin strobe; low for one cycle.
- SPI_REGBRIDGE_NEWSIGNAL_Out  out  1  one-cycle pulse for each accepted control write.
- SPI_REGBRIDGE_ERROR_Out  out  1  sticky protocol-error flag.

## Operation
**Input synchronisation**
- SS, SCK and MOSI each pass through a 2-flop synchroniser, followed by edge detection.
- For CPOL=0 the leading edge is rising; for CPOL=1 it is falling.
- For CPHA=0, MOSI is sampled on the leading edge and MISO shifts on the trailing edge. For CPHA=1 the roles swap.

**Transaction framing**
- A falling SS starts a transaction.
- The first byte received is the command: bit7=1 for a read, 0 for a write; bits6:0 give IDX.
- While the command byte is received, MISO shifts out the status byte: {2'b10, ERROR, stop_active, 1'b0, WAYSELECT}, where stop_active = ~STOPSIGNAL_OutLow.
- For CPHA=0, the status MSB is driven on MISO in the cycle after SS-fall detection.

**State machine**
- States: IDLE, CMD, RD_DATA, WR_CTRL, WR_IGNORE, WAIT_SS.
- IDLE→CMD when SS falls.
- CMD → RD_DATA or WR_CTRL on the 8th sampled bit.
- Any state → IDLE when SS rises.
- WR_CTRL → WR_IGNORE after one complete data byte.

**Reads**
- On command completion, all channels are latched into a snapshot register in one cycle.
- The burst then streams channel IDX, most significant byte first, BYTES_PER_CH bytes per channel.
- The channel index auto-increments after each channel and wraps from N_CH-1 to 0. The burst length is unbounded.
- If IDX ≥ N_CH: ERROR is set and every data byte is 0x00.

**Writes**
- IDX=0 selects the control register. Data byte bits:
  - bits2:0 → WAYSELECT.
  - bit3 → stop (1 drives STOPSIGNAL_OutLow=0).
  - bit4=1 → BEGIN pulse.
  - bit7=1 → clear ERROR.
- The control register updates, and NEWSIGNAL pulses, only when a complete data byte is received.
- Extra bytes (WR_IGNORE) are discarded and set ERROR.
- If IDX≠0: the byte is discarded, ERROR is set, and NEWSIGNAL does not pulse.

**Boundary conditions**
- SS rising mid-byte: the partial byte is discarded, the bit counter is cleared, and no register changes.
- If ERROR is cleared and set in the same cycle, set wins.

**Reset**
- Reset values: WAYSELECT=0, STOPSIGNAL_OutLow=0, BEGINSIGNAL_OutLow=1, NEWSIGNAL=0, ERROR=0, MISO=0. Status byte after reset is 0x90.
- Reset during a transaction enters WAIT_SS. All SPI activity is ignored until SS is high for at least one synchronised cycle.

## Timing
- Input latency: 2-cycle synchroniser plus 1-cycle edge detect.
- Control outputs, NEWSIGNAL and BEGIN update 4 cycles after the physical SCK edge that samples the last data bit.
- BEGIN and NEWSIGNAL are each exactly one cycle wide and occur in the same cycle.
- The snapshot is taken 4 cycles after the command's last sampling edge. Its first data bit is shifted out at least 4 clock cycles before the next driving edge.
- MISO changes at most 4 cycles after the driving edge, which is within half an SCK period at CLOCK_50/8.

## Test plan
- **Reset:** assert reset for 3 cycles → all outputs at reset values; a read command 0x80 returns status 0x90 on MISO.
- **Burst read:** channel2=17'h1ABCD, channel3=17'h00042, send 0x82 plus 6 bytes → MISO returns 0x90, 0x01, 0xAB, 0xCD, 0x00, 0x00, 0x42, in all four SPI_MODE values.
- **Coherency and wrap:** send command 0x8A; change channel10 and channel0 after the first data byte → the 6 returned bytes equal the pre-change snapshot of ch10 then ch0.
- **Control write:** write 0x00, 0x15 → WAYSELECT=5, STOPSIGNAL_OutLow=1, BEGIN low for 1 cycle, NEWSIGNAL high for 1 cycle; the next status byte is 0x85.
- **Abort:** write 0x00, then raise SS after 5 data bits → no output changes and no NEWSIGNAL; the next transaction decodes normally.
- **Errors:** send command 0x8B → data bytes 0x00, ERROR=1, status 0xB0 (stop still asserted). Then write 0x00, 0x88 → ERROR=0, stop asserted.
